// File: rtl/game_sequencer.sv
// game_sequencer: turn controller for the mastermind game.
// It latches the secret code and gates guess submission. It strobes history
// writes and feedback evaluation, and counts turns. It decides win or lose,
// holds the end-of-game display, then clears history for a new game.
module game_sequencer #(
    parameter int MAX_TURNS  = 8,
    parameter int HOLD_TICKS = 5,
    parameter int CODE_W     = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_select,
    input  logic              mode,
    input  logic              tick,
    input  logic              code_valid,
    input  logic [CODE_W-1:0] code_in,
    input  logic [CODE_W-1:0] guess_in,
    input  logic              eval_done,
    input  logic [2:0]        exact_cnt,
    input  logic [2:0]        partial_cnt,
    output logic              guess_enable,
    output logic              hist_wr,
    output logic              hist_clr,
    output logic [2:0]        turn,
    output logic              eval_start,
    output logic [CODE_W-1:0] eval_code,
    output logic [CODE_W-1:0] eval_guess,
    output logic              game_over,
    output logic              win,
    output logic [2:0]        state_dbg
);

    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    typedef enum logic [2:0] {
        SEED  = 3'd0,
        PLAY  = 3'd1,
        EVAL  = 3'd2,
        WIN   = 3'd3,
        LOSE  = 3'd4,
        CLEAR = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic                sel_q;
    logic [2:0]          turn_q, turn_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [CODE_W-1:0]   guess_q, guess_d;
    logic                submit;
    logic                sel_rise;
    logic                hist_wr_q, hist_clr_q, eval_start_q;
    logic                guess_en_q, game_over_q, win_q;

    // Feedback counts other than exact are not used for decisions.
    logic                unused_partial;
    assign unused_partial = ^partial_cnt;

    assign sel_rise = btn_select & ~sel_q;

    // Next-state, turn, hold-timer and latch decisions.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        state_d = state_q;
        turn_d  = turn_q;
        hold_d  = hold_q;
        code_d  = code_q;
        guess_d = guess_q;
        submit  = 1'b0;
        unique case (state_q)
            SEED: begin
                if (code_valid) begin
                    code_d  = code_in;
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (sel_rise && !mode) begin
                    submit  = 1'b1;
                    guess_d = guess_in;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (eval_done) begin
                    hold_d = '0;
                    if (exact_cnt == 3'd4) begin
                        state_d = WIN;
                    end else if (turn_q == 3'(MAX_TURNS - 1)) begin
                        state_d = LOSE;
                    end else begin
                        turn_d  = turn_q + 3'd1;
                        state_d = PLAY;
                    end
                end
            end
            WIN, LOSE: begin
                if (sel_rise || (tick && hold_q == HOLD_W'(HOLD_TICKS - 1))) begin
                    state_d = CLEAR;
                end else if (tick) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            CLEAR: begin
                turn_d  = '0;
                state_d = SEED;
            end
            default: state_d = SEED;
        endcase
    end

    // State, datapath latches and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SEED;
            // Treat select as already pressed so a held button cannot submit.
            sel_q        <= 1'b1;
            turn_q       <= '0;
            hold_q       <= '0;
            code_q       <= '0;
            guess_q      <= '0;
            hist_wr_q    <= 1'b0;
            hist_clr_q   <= 1'b0;
            eval_start_q <= 1'b0;
            guess_en_q   <= 1'b0;
            game_over_q  <= 1'b0;
            win_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q      <= state_d;
            sel_q        <= btn_select;
            turn_q       <= turn_d;
            hold_q       <= hold_d;
            code_q       <= code_d;
            guess_q      <= guess_d;
            hist_wr_q    <= submit;
            eval_start_q <= submit;
            hist_clr_q   <= (state_d == CLEAR);
            guess_en_q   <= (state_d == PLAY);
            game_over_q  <= (state_d == WIN) || (state_d == LOSE);
            win_q        <= (state_d == WIN);
        end
    end

    assign guess_enable = guess_en_q;
    assign hist_wr      = hist_wr_q;
    assign hist_clr     = hist_clr_q;
    assign turn         = turn_q;
    assign eval_start   = eval_start_q;
    assign eval_code    = code_q;
    assign eval_guess   = guess_q;
    assign game_over    = game_over_q;
    assign win          = win_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer with a guess scoreboard.
module tb_game_sequencer;

    localparam int CODE_W = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              btn_select = 1'b1;
    logic              mode = 1'b0;
    logic              tick = 1'b0;
    logic              code_valid = 1'b0;
    logic [CODE_W-1:0] code_in = '0;
    logic [CODE_W-1:0] guess_in = '0;
    logic              eval_done = 1'b0;
    logic [2:0]        exact_cnt = '0;
    logic [2:0]        partial_cnt = '0;
    logic              guess_enable, hist_wr, hist_clr, eval_start;
    logic              game_over, win;
    logic [2:0]        turn, state_dbg;
    logic [CODE_W-1:0] eval_code, eval_guess;

    int n_pass  = 0;
    int n_total = 0;
    int n_starts = 0;
    logic [CODE_W-1:0] exp_q[$];

    game_sequencer dut (
        .clk(clk), .rst_n(rst_n), .btn_select(btn_select), .mode(mode),
        .tick(tick), .code_valid(code_valid), .code_in(code_in),
        .guess_in(guess_in), .eval_done(eval_done), .exact_cnt(exact_cnt),
        .partial_cnt(partial_cnt), .guess_enable(guess_enable),
        .hist_wr(hist_wr), .hist_clr(hist_clr), .turn(turn),
        .eval_start(eval_start), .eval_code(eval_code),
        .eval_guess(eval_guess), .game_over(game_over), .win(win),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Count eval_start pulses away from the active edge.
    always @(negedge clk) if (eval_start === 1'b1) n_starts++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Press select with a guess. Check the strobes one cycle later and pop
    // the scoreboard entry against eval_guess.
    task automatic submit(input logic [CODE_W-1:0] g);
        logic [CODE_W-1:0] e;
        guess_in   = g;
        btn_select = 1'b1;
        exp_q.push_back(g);
        step();
        btn_select = 1'b0;
        guess_in   = ~g;
        check("submit_hist_wr", 32'(hist_wr), 32'd1);
        check("submit_eval_start", 32'(eval_start), 32'd1);
        check("submit_state_eval", 32'(state_dbg), 32'd2);
        if (hist_wr === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("submit_eval_guess", 32'(eval_guess), 32'(e));
        end
        step();
        check("submit_hist_wr_pulse", 32'(hist_wr), 32'd0);
    endtask

    task automatic done(input logic [2:0] ex);
        eval_done = 1'b1;
        exact_cnt = ex;
        partial_cnt = 3'd1;
        step();
        eval_done = 1'b0;
        exact_cnt = '0;
    endtask

    task automatic load_code(input logic [CODE_W-1:0] c);
        code_in = c;
        code_valid = 1'b1;
        step();
        code_valid = 1'b0;
        check("load_state_play", 32'(state_dbg), 32'd1);
        check("load_eval_code", 32'(eval_code), 32'(c));
        check("load_guess_enable", 32'(guess_enable), 32'd1);
    endtask

    initial begin
        int starts0;
        bit seen;
        // 1: reset with select held, then load a code.
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_outputs", {hist_wr, hist_clr, eval_start, guess_enable, game_over, win, turn},
              32'd0);
        check("rst_code", 32'(eval_code), 32'd0);
        rst_n = 1'b1;
        step();
        step();
        check("held_sel_no_wr", 32'(hist_wr), 32'd0);
        check("seed_wait", 32'(state_dbg), 32'd0);
        load_code(12'h29C);
        check("t1_turn", 32'(turn), 32'd0);
        step();
        check("held_sel_play_no_wr", 32'(hist_wr), 32'd0);
        btn_select = 1'b0;
        step();

        // 2: submit, then feedback with two exact pegs.
        submit(12'h123);
        check("eval_guess_disabled", 32'(guess_enable), 32'd0);
        done(3'd2);
        check("t2_state_play", 32'(state_dbg), 32'd1);
        check("t2_turn", 32'(turn), 32'd1);

        // 3: review mode blocks submission; a second press in EVAL is dropped.
        starts0 = n_starts;
        mode = 1'b1;
        btn_select = 1'b1;
        step();
        btn_select = 1'b0;
        step();
        mode = 1'b0;
        check("review_no_wr", 32'(hist_wr), 32'd0);
        check("review_state", 32'(state_dbg), 32'd1);
        check("review_no_start", 32'(n_starts - starts0), 32'd0);
        submit(12'h456);
        btn_select = 1'b1;
        step();
        btn_select = 1'b0;
        step();
        check("eval_press_state", 32'(state_dbg), 32'd2);
        check("eval_press_wr", 32'(hist_wr), 32'd0);
        check("single_start", 32'(n_starts - starts0), 32'd1);
        done(3'd1);
        check("t3_turn", 32'(turn), 32'd2);
        submit(12'h456);
        done(3'd0);
        check("t4_turn", 32'(turn), 32'd3);

        // 4: win on turn 3, hold for the tick interval, then clear.
        submit(12'h29C);
        done(3'd4);
        check("win_state", 32'(state_dbg), 32'd3);
        check("win_flags", {game_over, win, guess_enable}, 32'b110);
        check("win_turn", 32'(turn), 32'd3);
        repeat (4) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
        check("win_hold_4", 32'(state_dbg), 32'd3);
        tick = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            step();
            tick = 1'b0;
            if (hist_clr === 1'b1) seen = 1'b1;
        end
        check("win_hist_clr_seen", 32'(seen), 32'd1);
        check("clear_state", 32'(state_dbg), 32'd5);
        step();
        check("clear_one_cycle", 32'(hist_clr), 32'd0);
        check("after_clear", {state_dbg, turn, game_over, win}, 32'd0);

        // 5: eight non-winning guesses lose; select plus tick restarts once.
        load_code(12'h555);
        for (int i = 0; i < 8; i++) begin
            submit((i == 3) ? 12'h111 : 12'h111 + 12'(i));
            done((i == 5) ? 3'd5 : 3'd3);
            if (i < 7) check("lose_turn_step", 32'(turn), 32'(i + 1));
        end
        check("lose_state", 32'(state_dbg), 32'd4);
        check("lose_turn", 32'(turn), 32'd7);
        check("lose_flags", {game_over, win}, 32'b10);
        step();
        btn_select = 1'b1;
        tick = 1'b1;
        step();
        btn_select = 1'b0;
        tick = 1'b0;
        check("early_clear", 32'(state_dbg), 32'd5);
        check("early_hist_clr", 32'(hist_clr), 32'd1);
        step();
        check("early_seed", {state_dbg, hist_clr, turn}, 32'd0);

        // 6: reset during EVAL, then a late eval_done.
        load_code(12'h0F0);
        submit(12'h777);
        rst_n = 1'b0;
        #1;
        check("async_rst", {state_dbg, hist_wr, eval_start, turn, game_over, win, guess_enable},
              32'd0);
        check("async_rst_code", 32'(eval_code), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        done(3'd4);
        check("late_done_ignored", {state_dbg, game_over, win, turn}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level turn controller for the mastermind game; sits between the debounced select/mode inputs and the history, PRNG-code and feedback datapath.
- Latches a secret code and gates guess submission.
- Writes each guess into history, launches feedback evaluation with a start/done handshake, and counts turns.
- Decides win or lose, holds the end-of-game display for a timed interval, then clears history and starts a new game.

Parameters:
- MAX_TURNS, 8, guesses allowed per game (1..8; turn index fits 3 bits, one sw_led per turn).
- HOLD_TICKS, 5, tick pulses the WIN/LOSE state is held before auto-restart.
- CODE_W, 12, packed code/guess width (4 pegs x 3 bits; peg0 in [2:0]).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- btn_select  in  1  debounced select level.
- mode  in  1  0 = play, 1 = history review (submission blocked).
- tick  in  1  one-cycle timebase pulse (1 Hz enable) for the hold timer.
- code_valid  in  1  PRNG code stable this cycle.
- code_in  in  CODE_W  PRNG code.
- guess_in  in  CODE_W  current guess from the guess editor.
- eval_done  in  1  one-cycle pulse; exact/partial valid.
- exact_cnt  in  3  pegs right colour, right place (0..4).
- partial_cnt  in  3  pegs right colour, wrong place.
- guess_enable  out  1  guess editor may accept edits.
- hist_wr  out  1  one-cycle history write strobe.
- hist_clr  out  1  one-cycle history clear strobe.
- turn  out  3  current turn index.
- eval_start  out  1  one-cycle feedback start pulse.
- eval_code  out  CODE_W  latched secret code.
- eval_guess  out  CODE_W  latched submitted guess.
- game_over  out  1  high in WIN or LOSE.
- win  out  1  high in WIN only.
- state_dbg  out  3  encoded FSM state.

Behaviour:
- All outputs are registered. Reset values: all outputs 0; state = SEED (state_dbg 0); sel_q = 1, so a select held through reset never submits.
- sel_rise = btn_select & ~sel_q. sel_q samples btn_select every cycle.
- State encodings: SEED=0, PLAY=1, EVAL=2, WIN=3, LOSE=4, CLEAR=5.
- SEED: guess_enable=0. On code_valid, latch eval_code <= code_in and go to PLAY next cycle.
- PLAY: guess_enable=1. On sel_rise with mode=0 in cycle N:
  - cycle N+1: eval_guess = guess_in sampled at cycle N; hist_wr = 1; eval_start = 1; state = EVAL.
  - sel_rise with mode=1 is ignored, with no side effects.
- EVAL: guess_enable=0. Ignore sel_rise and mode. On eval_done:
  - exact_cnt == 4 -> WIN.
  - else turn == MAX_TURNS-1 -> LOSE.
  - else turn <= turn+1 -> PLAY.
  - partial_cnt is not used for decisions.
- eval_done outside EVAL is ignored. exact_cnt > 4 is treated as a non-win.
- WIN/LOSE:
  - game_over=1; win=1 only in WIN; guess_enable=0; turn is frozen.
  - Hold counter clears on entry and increments on tick.
  - Leave for CLEAR when the counter reaches HOLD_TICKS, or on sel_rise (early restart).
  - tick and sel_rise in the same cycle -> CLEAR, counted once.
- CLEAR: one cycle. hist_clr=1, turn <= 0, game_over <= 0, win <= 0. Then SEED, and a new code is latched on the next code_valid.
- A repeated or duplicate guess is a legal submission and consumes a turn.
- turn never exceeds MAX_TURNS-1 and never wraps.
- Reset asserted mid-EVAL or mid-hold aborts immediately to reset values; a pending eval_done after reset is ignored.
- Back-to-back select: a second sel_rise before eval_done is dropped. The button must be released and re-pressed in PLAY.

Test Plan:
1. Reset with btn_select=1, code_valid pulsed with code 0x29C -> no hist_wr; state SEED->PLAY; eval_code=0x29C; turn=0.
2. Select in PLAY, guess 0x123, mode=0 -> next cycle hist_wr=1, eval_start=1, eval_guess=0x123. eval_done with exact=2 -> PLAY, turn=1.
3. Select with mode=1 -> no strobes, state stays PLAY. Select pressed again during EVAL -> ignored, single eval_start observed.
4. Eval_done with exact=4 on turn 3 -> WIN, game_over=1, win=1, turn=3. After 5 tick pulses -> one hist_clr cycle, turn=0, then SEED.
5. Eight non-winning guesses -> the 8th eval_done gives LOSE, turn=7, win=0. Select during the hold -> immediate CLEAR.
6. rst_n asserted low while in EVAL, then eval_done arrives after release -> all outputs 0, state SEED, eval_done ignored.
